// File: rtl/tx_valid_scheduler.sv
// Rate and sequencing controller for the TX PCS chain: block valid, lane-group valid, AM marking.
// Latency: first block valid CLK_DIV+1 cycles after enable; no backpressure, the pulses are free-running while busy.
module tx_valid_scheduler #(
  parameter int CLK_DIV         = 2,
  parameter int N_LANES         = 20,
  parameter int AM_BLOCK_PERIOD = 16383,
  parameter int FILL_GROUPS     = 2,
  parameter int NB_DIV_CNT      = 4,
  parameter int NB_LANE_IDX     = 5,
  parameter int NB_AM_CNT       = 14
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  output logic                   o_fast_valid,
  output logic                   o_slow_valid,
  output logic [NB_LANE_IDX-1:0] o_lane_idx,
  output logic                   o_am_insert,
  output logic                   o_running,
  output logic                   o_busy
);

  localparam int NB_FILL = (FILL_GROUPS > 1) ? $clog2(FILL_GROUPS) : 1;

  localparam logic [NB_DIV_CNT-1:0]  DIV_LAST  = NB_DIV_CNT'(CLK_DIV - 1);
  localparam logic [NB_LANE_IDX-1:0] LANE_LAST = NB_LANE_IDX'(N_LANES - 1);
  localparam logic [NB_AM_CNT-1:0]   AM_LAST   = NB_AM_CNT'(AM_BLOCK_PERIOD - 1);
  localparam logic [NB_FILL-1:0]     FILL_LAST = NB_FILL'(FILL_GROUPS - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t                 state;
  logic [NB_DIV_CNT-1:0]  div_cnt;
  logic [NB_LANE_IDX-1:0] lane_cnt;
  logic [NB_FILL-1:0]     fill_cnt;
  logic [NB_AM_CNT-1:0]   am_cnt;

  logic tick;
  logic group_end;
  logic advance;

  assign tick      = (state != IDLE) && (div_cnt == DIV_LAST);
  assign group_end = tick && (lane_cnt == LANE_LAST);
  // A FILL abort drops the divider on the spot, so it must not advance that cycle.
  assign advance   = (state == RUN) || (state == DRAIN) || ((state == FILL) && i_enable);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      lane_cnt     <= '0;
      fill_cnt     <= '0;
      am_cnt       <= '0;
      o_fast_valid <= 1'b0;
      o_slow_valid <= 1'b0;
      o_lane_idx   <= '0;
      o_am_insert  <= 1'b0;
      o_running    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_fast_valid <= 1'b0;
      o_slow_valid <= 1'b0;
      o_am_insert  <= 1'b0;
      o_running    <= (state == RUN);
      o_busy       <= (state != IDLE);

      if (advance) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          lane_cnt     <= (lane_cnt == LANE_LAST) ? '0 : lane_cnt + 1'b1;
          o_fast_valid <= 1'b1;
          o_lane_idx   <= lane_cnt;
        end
      end

      case (state)
        IDLE: begin
          div_cnt  <= '0;
          lane_cnt <= '0;
          fill_cnt <= '0;
          am_cnt   <= '0;
          if (i_enable) state <= (FILL_GROUPS == 0) ? RUN : FILL;
        end
        FILL: begin
          if (!i_enable) begin
            state    <= IDLE;
            div_cnt  <= '0;
            lane_cnt <= '0;
            fill_cnt <= '0;
            am_cnt   <= '0;
          end else if (group_end) begin
            if (fill_cnt == FILL_LAST) begin
              state    <= RUN;
              fill_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        RUN, DRAIN: begin
          if (group_end) begin
            o_slow_valid <= 1'b1;
            o_am_insert  <= (am_cnt == '0);
            am_cnt       <= (am_cnt == AM_LAST) ? '0 : am_cnt + 1'b1;
            // The closing group's slow valid still goes out; the AM phase restarts from IDLE.
            if ((state == DRAIN) || !i_enable) begin
              state  <= IDLE;
              am_cnt <= '0;
            end
          end else if ((state == RUN) && !i_enable) begin
            state <= DRAIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_valid_scheduler.sv
// Bench for tx_valid_scheduler: three parameterisations, per-pulse scoreboard plus a scenario table.
module tb_tx_valid_scheduler;

  localparam int NL = 20;

  typedef struct {
    int cyc;
    int lane;
    bit slow;
    bit am;
    bit chk_run;
  } exp_t;

  typedef struct {
    int d;
    int k;
    bit glitch;
    int ef;
    int es;
    int ea;
    int efall;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en   [3];
  logic       fv   [3];
  logic       sv   [3];
  logic       am   [3];
  logic       run  [3];
  logic       busy [3];
  logic [4:0] li   [3];

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   act = -1;
  int   n_fast, n_slow, n_am;
  int   last_pulse_cyc, fall_cyc;
  bit   prev_busy [3];
  exp_t sb[$];
  vec_t tbl[10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tx_valid_scheduler #(.CLK_DIV(2), .AM_BLOCK_PERIOD(16383), .FILL_GROUPS(2)) u_d0 (
    .i_clock(clk), .i_reset(rst), .i_enable(en[0]), .o_fast_valid(fv[0]), .o_slow_valid(sv[0]),
    .o_lane_idx(li[0]), .o_am_insert(am[0]), .o_running(run[0]), .o_busy(busy[0]));

  tx_valid_scheduler #(.CLK_DIV(2), .AM_BLOCK_PERIOD(4), .FILL_GROUPS(2)) u_d1 (
    .i_clock(clk), .i_reset(rst), .i_enable(en[1]), .o_fast_valid(fv[1]), .o_slow_valid(sv[1]),
    .o_lane_idx(li[1]), .o_am_insert(am[1]), .o_running(run[1]), .o_busy(busy[1]));

  tx_valid_scheduler #(.CLK_DIV(1), .AM_BLOCK_PERIOD(3), .FILL_GROUPS(0)) u_d2 (
    .i_clock(clk), .i_reset(rst), .i_enable(en[2]), .o_fast_valid(fv[2]), .o_slow_valid(sv[2]),
    .o_lane_idx(li[2]), .o_am_insert(am[2]), .o_running(run[2]), .o_busy(busy[2]));

  function automatic int cd_of(input int d);
    return (d == 2) ? 1 : 2;
  endfunction

  function automatic int fg_of(input int d);
    return (d == 2) ? 0 : 2;
  endfunction

  function automatic int amp_of(input int d);
    return (d == 0) ? 16383 : ((d == 1) ? 4 : 3);
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Enable sampled at edge s; block j appears after edge s+CLK_DIV*(j+1). Enable dropped after
  // block k is seen: a FILL abort stops at k, otherwise blocks run to the next lane N-1.
  task automatic push_exp(input int d, input int k, input int s);
    int   nf;
    int   sidx;
    exp_t e;
    if (k < NL * fg_of(d) - 1) nf = k + 1;
    else nf = ((k + 1) / NL) * NL + NL;
    sidx = 0;
    for (int j = 0; j < nf; j++) begin
      e.cyc     = s + cd_of(d) * (j + 1);
      e.lane    = j % NL;
      e.slow    = (j % NL == NL - 1) && (j >= NL * fg_of(d));
      e.am      = e.slow && (sidx % amp_of(d) == 0);
      e.chk_run = e.slow && (j <= k);
      if (e.slow) sidx++;
      sb.push_back(e);
    end
  endtask

  task automatic step();
    exp_t e;
    bit   ok;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (fv[d]) begin
        if (d != act || sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse d%0d: got fast valid at cyc %0d, expected none", d, cyc);
        end else begin
          e  = sb.pop_front();
          ok = (cyc == e.cyc) && (int'(li[d]) == e.lane) && (sv[d] == e.slow) && (am[d] == e.am)
               && (!e.chk_run || run[d]);
          n_vec++;
          if (!ok) begin
            n_err++;
            $display("FAIL pulse d%0d: got cyc=%0d lane=%0d slow=%0d am=%0d run=%0d, expected cyc=%0d lane=%0d slow=%0d am=%0d run=%0d",
                     d, cyc, li[d], sv[d], am[d], run[d], e.cyc, e.lane, e.slow, e.am, e.chk_run);
          end
          n_fast++;
          if (sv[d]) n_slow++;
          if (am[d]) n_am++;
          last_pulse_cyc = cyc;
        end
      end else if (sv[d] || am[d]) begin
        n_vec++;
        n_err++;
        $display("FAIL orphan_slow d%0d: got slow=%0d am=%0d without fast valid at cyc %0d, expected 0",
                 d, sv[d], am[d], cyc);
      end
      if (d == act && prev_busy[d] && !busy[d]) fall_cyc = cyc;
      prev_busy[d] = busy[d];
    end
  endtask

  task automatic run_scn(input vec_t v);
    int s;
    int guard;
    bit dropped;
    act    = v.d;
    n_fast = 0;
    n_slow = 0;
    n_am   = 0;
    fall_cyc = -1;
    last_pulse_cyc = -1;
    s = cyc + 1;
    en[v.d] = 1'b1;
    push_exp(v.d, v.k, s);
    dropped = 1'b0;
    guard   = 0;
    while (!(dropped && sb.size() == 0 && !busy[v.d]) && guard < 3000) begin
      step();
      guard++;
      if (!dropped && n_fast == v.k + 1) begin
        en[v.d] = 1'b0;
        dropped = 1'b1;
      end
      // Re-request during DRAIN; it must not extend the drain.
      if (v.glitch && n_fast == v.k + 5) en[v.d] = 1'b1;
      if (v.glitch && n_fast == v.k + 7) en[v.d] = 1'b0;
    end
    chk($sformatf("drain_done_in_budget d%0d k%0d", v.d, v.k), int'(guard < 3000), 1);
    repeat (4) step();
    chk($sformatf("n_fast d%0d k%0d", v.d, v.k), n_fast, v.ef);
    chk($sformatf("n_slow d%0d k%0d", v.d, v.k), n_slow, v.es);
    chk($sformatf("n_am d%0d k%0d", v.d, v.k), n_am, v.ea);
    chk($sformatf("busy_fall d%0d k%0d", v.d, v.k), fall_cyc - last_pulse_cyc, v.efall);
    act = -1;
  endtask

  initial begin
    int g;
    tbl[0] = '{0, 79, 1'b0, 100, 3, 1, 1};
    tbl[1] = '{0, 67, 1'b1, 80, 2, 1, 1};
    tbl[2] = '{0, 25, 1'b0, 26, 0, 0, 2};
    tbl[3] = '{0, 38, 1'b0, 39, 0, 0, 2};
    tbl[4] = '{0, 39, 1'b0, 60, 1, 1, 1};
    tbl[5] = '{1, 319, 1'b0, 340, 15, 4, 1};
    tbl[6] = '{1, 99, 1'b0, 120, 4, 1, 1};
    tbl[7] = '{2, 45, 1'b0, 60, 3, 1, 1};
    tbl[8] = '{2, 38, 1'b0, 40, 2, 1, 1};
    tbl[9] = '{2, 59, 1'b0, 80, 4, 2, 1};

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      en[d] = 1'b0;
      prev_busy[d] = 1'b0;
    end
    repeat (3) step();
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset_outputs d%0d", d), int'({fv[d], sv[d], am[d], run[d], busy[d], li[d]}), 0);
    rst = 1'b0;
    repeat (100) step();
    for (int d = 0; d < 3; d++)
      chk($sformatf("idle_outputs d%0d", d), int'({run[d], busy[d], li[d]}), 0);

    // Asynchronous reset in the middle of a RUN group, while lane 11 is showing.
    act = 0;
    n_fast = 0;
    n_slow = 0;
    n_am = 0;
    en[0] = 1'b1;
    push_exp(0, 1000, cyc + 1);
    g = 0;
    while (n_fast < 72 && g < 500) begin
      step();
      g++;
    end
    chk("reach_lane11", n_fast, 72);
    chk("lane11_idx", int'(li[0]), 11);
    chk("lane11_running", int'(run[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_clears", int'({fv[0], sv[0], am[0], run[0], busy[0], li[0]}), 0);
    sb.delete();
    en[0] = 1'b0;
    act = -1;
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) run_scn(tbl[i]);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
